// File: rtl/md6_step_sched.sv
// md6_step_sched
//   Step scheduler for the MD6 compression-function datapath. A start request
//   sequences 16*rounds compression steps. Each step presents its index, the
//   right/left shift amounts from the packed 16-slot tables, and the current
//   round constant S, through a valid/ready handshake.
//
// Build option:
//   MD6_SCHED_ABORT_EN - adds the abort input. Abort in RUN returns to IDLE
//                        with no done pulse.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, rounds       - start request (IDLE only), round count
//   rshift, lshift      - packed shift tables, slot k = [8k+7:8k]
//   step_ready          - datapath accepts the current step
//   step_valid          - step fields valid (RUN)
//   step_idx            - step number from 0
//   r_amt, l_amt        - shift amounts for the current step (0 outside RUN)
//   s_const             - round constant for the current step
//   last_step           - final step presented
//   busy, done          - high in RUN/DONE; one-cycle completion pulse
//   abort               - (MD6_SCHED_ABORT_EN only) cancel the current run
module md6_step_sched #(
   parameter int unsigned ROUNDS_W = 8,
   parameter logic [63:0] S0       = 64'h0123456789ABCDEF,
   parameter logic [63:0] SSTAR    = 64'h7311C2812425CFA0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROUNDS_W-1:0]   rounds,
   input  logic [127:0]          rshift,
   input  logic [127:0]          lshift,
   input  logic                  step_ready,
   output logic                  step_valid,
   output logic [ROUNDS_W+3:0]   step_idx,
   output logic [7:0]            r_amt,
   output logic [7:0]            l_amt,
   output logic [63:0]           s_const,
   output logic                  last_step,
   output logic                  busy,
   output logic                  done
`ifdef MD6_SCHED_ABORT_EN
   ,
   input  logic                  abort
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ROUNDS_W+3:0]   r_idx;
   logic [ROUNDS_W+3:0]   r_total;
   logic [63:0]           r_s;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_abort;
   logic                  w_load;

`ifdef MD6_SCHED_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_last = (r_idx == (r_total - 1'b1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_load     = 1'b0;
      step_valid = 1'b0;
      last_step  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      r_amt      = '0;
      l_amt      = '0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load = (rounds != '0);
               w_next = (rounds != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            step_valid = 1'b1;
            busy       = 1'b1;
            last_step  = w_last;
            r_amt      = rshift[{r_idx[3:0], 3'b000} +: 8];
            l_amt      = lshift[{r_idx[3:0], 3'b000} +: 8];
            // Abort wins over a simultaneous acceptance.
            w_accept   = step_ready && !w_abort;
            if (w_abort)               w_next = ST_IDLE;
            else if (w_accept && w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_total <= '0;
         r_s     <= S0;
      end else if (w_load) begin
         r_idx   <= '0;
         r_total <= {rounds, 4'b0000};
         r_s     <= S0;
      end else if (w_accept && !w_last) begin
         r_idx <= r_idx + 1'b1;
         // Round boundary: S <- rotl1(S) ^ (S & S*)
         if (r_idx[3:0] == 4'hF)
            r_s <= {r_s[62:0], r_s[63]} ^ (r_s & SSTAR);
      end
   end

   assign step_idx = r_idx;
   assign s_const  = r_s;

endmodule

// File: tb/tb_md6_step_sched.sv
// Self-checking bench for md6_step_sched. Expected step fields come from a
// per-step reference: slot k%16 of the shift tables and S advanced k/16 times.
module tb_md6_step_sched;

   localparam int unsigned RW    = 8;
   localparam logic [63:0] TB_S0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] TB_SS = 64'h7311C2812425CFA0;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [RW-1:0]   rounds_i;
   logic [127:0]    rshift_i;
   logic [127:0]    lshift_i;
   logic            step_ready_i;
   logic            abort_i;
   logic            step_valid;
   logic [RW+3:0]   step_idx;
   logic [7:0]      r_amt;
   logic [7:0]      l_amt;
   logic [63:0]     s_const;
   logic            last_step;
   logic            busy;
   logic            done;

   int checks = 0;
   int errors = 0;

   byte unsigned rt[16];
   byte unsigned lt[16];

   md6_step_sched #(.ROUNDS_W(RW), .S0(TB_S0), .SSTAR(TB_SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_i),
      .rounds     (rounds_i),
      .rshift     (rshift_i),
      .lshift     (lshift_i),
      .step_ready (step_ready_i),
      .step_valid (step_valid),
      .step_idx   (step_idx),
      .r_amt      (r_amt),
      .l_amt      (l_amt),
      .s_const    (s_const),
      .last_step  (last_step),
      .busy       (busy),
      .done       (done)
`ifdef MD6_SCHED_ABORT_EN
      ,
      .abort      (abort_i)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // S after n round-constant updates.
   function automatic logic [63:0] s_model(input int n);
      logic [63:0] s;
      s = TB_S0;
      for (int i = 0; i < n; i++)
         s = ((s << 1) | (s >> 63)) ^ (s & TB_SS);
      return s;
   endfunction

   task automatic load_tables();
      for (int i = 0; i < 16; i++) begin
         rshift_i[8*i +: 8] = rt[i];
         lshift_i[8*i +: 8] = lt[i];
      end
   endtask

   task automatic random_tables();
      for (int i = 0; i < 16; i++) begin
         rt[i] = 8'($urandom);
         lt[i] = 8'($urandom);
      end
      load_tables();
   endtask

   // mode 0: ready always high; 1: ready low/high alternating starting low;
   // 2: random ready. restart pulses start while step 5 is presented.
   // Entered and left at posedge+1 with the DUT in IDLE.
   task automatic run(input int rnds, input int mode, input bit restart);
      int k;
      int cyc;
      int total;
      k     = 0;
      cyc   = 0;
      total = 16 * rnds;
      rounds_i = RW'(rnds);
      start_i  = 1'b1;
      @(posedge clk); #1;
      start_i  = 1'b0;
      rounds_i = RW'($urandom);
      while (k < total && cyc < 4000) begin
         case (mode)
            0:       step_ready_i = 1'b1;
            1:       step_ready_i = (cyc % 2 == 1);
            default: step_ready_i = 1'($urandom_range(0, 1));
         endcase
         if (restart && k == 5) begin
            start_i  = 1'b1;
            rounds_i = RW'($urandom_range(1, 4));
         end
         #1;
         chk("step_valid", step_valid, 1'b1);
         chk("step_idx", step_idx, k);
         chk("r_amt", r_amt, rt[k % 16]);
         chk("l_amt", l_amt, lt[k % 16]);
         chk("s_const", s_const, s_model(k / 16));
         chk("last_step", last_step, (k == total - 1));
         chk("busy_run", busy, 1'b1);
         chk("done_run", done, 1'b0);
         if (step_ready_i) k++;
         cyc++;
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      chk("steps_accepted", k, total);
      if (mode == 0) chk("run_cycles", cyc, total);
      if (mode == 1) chk("run_cycles_bp", cyc, 2 * total);
      step_ready_i = 1'b0;
      chk("done_pulse", done, 1'b1);
      chk("valid_in_done", step_valid, 1'b0);
      chk("busy_in_done", busy, 1'b1);
      chk("r_amt_in_done", r_amt, 8'd0);
      @(posedge clk); #1;
      chk("done_cleared", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("valid_idle", step_valid, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      start_i      = 1'b0;
      rounds_i     = '0;
      step_ready_i = 1'b0;
      abort_i      = 1'b0;
      rshift_i     = '0;
      lshift_i     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", step_valid, 1'b0);
      chk("rst_idx", step_idx, 0);
      chk("rst_r_amt", r_amt, 8'd0);
      chk("rst_l_amt", l_amt, 8'd0);
      chk("rst_s", s_const, TB_S0);
      chk("rst_last", last_step, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Single round, MD6 standard tables
      rt = '{10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12};
      lt = '{11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9};
      load_tables();
      run(1, 0, 1'b0);

      // Round constant update across the round boundary
      run(2, 0, 1'b0);

      // Backpressure
      run(1, 1, 1'b0);

      // Zero rounds
      rounds_i = '0;
      start_i  = 1'b1;
      @(posedge clk); #1;
      start_i  = 1'b0;
      chk("zero_done", done, 1'b1);
      chk("zero_valid", step_valid, 1'b0);
      chk("zero_busy", busy, 1'b1);
      @(posedge clk); #1;
      chk("zero_done_clr", done, 1'b0);
      chk("zero_valid2", step_valid, 1'b0);
      chk("zero_busy2", busy, 1'b0);

      // Start during RUN ignored, random tables and random ready
      random_tables();
      run(3, 2, 1'b1);

      for (int i = 0; i < 3; i++) begin
         random_tables();
         run($urandom_range(1, 3), 2, 1'b0);
      end

      // Asynchronous reset mid-run, after S has advanced
      rounds_i     = 8'd2;
      start_i      = 1'b1;
      @(posedge clk); #1;
      start_i      = 1'b0;
      step_ready_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("pre_rst_s", s_const, s_model(1));
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", step_valid, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_s", s_const, TB_S0);
      chk("async_rst_idx", step_idx, 0);
      chk("async_rst_done", done, 1'b0);
      step_ready_i = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_valid", step_valid, 1'b0);

`ifdef MD6_SCHED_ABORT_EN
      // Abort at step 5
      rounds_i     = 8'd1;
      start_i      = 1'b1;
      @(posedge clk); #1;
      start_i      = 1'b0;
      step_ready_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_at_idx", step_idx, 5);
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i      = 1'b0;
      step_ready_i = 1'b0;
      chk("abort_valid", step_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      @(posedge clk); #1;
      chk("abort_no_done", done, 1'b0);
      run(1, 0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
